// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU control codes, ALU-op classes, funct
// values and the ID/EX pipeline register layout.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_SLL     = 4'b1001,
    ALU_SRL     = 4'b1010,
    ALU_XOR     = 4'b1011,
    ALU_NOR     = 4'b1100,
    ALU_INVALID = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        alusrc;
    logic [3:0]  alu_ctrl;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } ex_entry_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle plus the MEM/WB forwarding sources.
// idValid qualifies the decode bundle; when stall is 1 the bundle is not
// accepted at that edge and decode must hold it unchanged for the next cycle.
interface id_ex_stage_if;
  import mips_pkg::*;

  logic        flush;
  logic        idValid, idRegWrite, idMemRead, idMemWrite, idMemToReg;
  logic        idBranch, idAluSrc, idRegDst;
  logic [1:0]  idAluOp;
  logic [5:0]  idFunct;
  logic [4:0]  idShamt;
  logic [4:0]  idRs, idRt, idRd;
  logic [31:0] idReadData1, idReadData2, idImm;
  logic        memRegWrite;
  logic [4:0]  memWriteReg;
  logic [31:0] memAluResult;
  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData;

  logic        stall;
  logic [31:0] exAluIn1, exAluIn2, exStoreData;
  logic [3:0]  exAluControl;
  logic [4:0]  exShamt;
  logic [4:0]  exWriteReg;
  logic        exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch;

  modport master (
    output flush, idValid, idRegWrite, idMemRead, idMemWrite, idMemToReg,
           idBranch, idAluSrc, idRegDst, idAluOp, idFunct, idShamt,
           idRs, idRt, idRd, idReadData1, idReadData2, idImm,
           memRegWrite, memWriteReg, memAluResult,
           wbRegWrite, wbWriteReg, wbWriteData,
    input  stall, exAluIn1, exAluIn2, exStoreData, exAluControl, exShamt,
           exWriteReg, exValid, exRegWrite, exMemRead, exMemWrite,
           exMemToReg, exBranch
  );

  modport slave (
    input  flush, idValid, idRegWrite, idMemRead, idMemWrite, idMemToReg,
           idBranch, idAluSrc, idRegDst, idAluOp, idFunct, idShamt,
           idRs, idRt, idRd, idReadData1, idReadData2, idImm,
           memRegWrite, memWriteReg, memAluResult,
           wbRegWrite, wbWriteReg, wbWriteData,
    output stall, exAluIn1, exAluIn2, exStoreData, exAluControl, exShamt,
           exWriteReg, exValid, exRegWrite, exMemRead, exMemWrite,
           exMemToReg, exBranch
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// ALU-op class plus funct to 4-bit ALU control code. Purely combinational;
// shared with the single-cycle datapath.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_INVALID;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_OR:  alu_ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: alu_ctrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctrl = ALU_SUB;
          FUNCT_AND:             alu_ctrl = ALU_AND;
          FUNCT_OR:              alu_ctrl = ALU_OR;
          FUNCT_XOR:             alu_ctrl = ALU_XOR;
          FUNCT_NOR:             alu_ctrl = ALU_NOR;
          FUNCT_SLT:             alu_ctrl = ALU_SLT;
          FUNCT_SLL:             alu_ctrl = ALU_SLL;
          FUNCT_SRL:             alu_ctrl = ALU_SRL;
          default:               alu_ctrl = ALU_INVALID;
        endcase
      end
      default: alu_ctrl = ALU_INVALID;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX operand forwarding
// from MEM/WB, load-use hazard detection and flush handling.
module id_ex_stage
  import mips_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  ex_entry_t   ex_q, ex_d;
  logic [3:0]  dec_ctrl;
  logic        hazard;
  logic [31:0] fwd_rs, fwd_rt;

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op   (bus.idAluOp),
    .funct    (bus.idFunct),
    .alu_ctrl (dec_ctrl)
  );

  // A load in EX whose destination is read by the instruction in ID.
  assign hazard = ex_q.valid & ex_q.memread & (ex_q.write_reg != 5'd0) &
                  ((ex_q.write_reg == bus.idRs) | (ex_q.write_reg == bus.idRt)) &
                  bus.idValid;
  assign bus.stall = hazard;

  always_comb begin
    ex_d = '0;
    if (!bus.flush && !hazard) begin
      ex_d.valid     = bus.idValid;
      ex_d.regwrite  = bus.idRegWrite;
      ex_d.memread   = bus.idMemRead;
      ex_d.memwrite  = bus.idMemWrite;
      ex_d.memtoreg  = bus.idMemToReg;
      ex_d.branch    = bus.idBranch;
      ex_d.alusrc    = bus.idAluSrc;
      ex_d.alu_ctrl  = dec_ctrl;
      ex_d.shamt     = bus.idShamt;
      ex_d.rs        = bus.idRs;
      ex_d.rt        = bus.idRt;
      ex_d.write_reg = bus.idRegDst ? bus.idRd : bus.idRt;
      ex_d.rd1       = bus.idReadData1;
      ex_d.rd2       = bus.idReadData2;
      ex_d.imm       = bus.idImm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // MEM is the younger producer, so it wins over WB; $0 never forwards.
  always_comb begin
    fwd_rs = ex_q.rd1;
    if (bus.memRegWrite && (bus.memWriteReg != 5'd0) && (bus.memWriteReg == ex_q.rs))
      fwd_rs = bus.memAluResult;
    else if (bus.wbRegWrite && (bus.wbWriteReg != 5'd0) && (bus.wbWriteReg == ex_q.rs))
      fwd_rs = bus.wbWriteData;

    fwd_rt = ex_q.rd2;
    if (bus.memRegWrite && (bus.memWriteReg != 5'd0) && (bus.memWriteReg == ex_q.rt))
      fwd_rt = bus.memAluResult;
    else if (bus.wbRegWrite && (bus.wbWriteReg != 5'd0) && (bus.wbWriteReg == ex_q.rt))
      fwd_rt = bus.wbWriteData;
  end

  assign bus.exAluIn1     = fwd_rs;
  assign bus.exAluIn2     = ex_q.alusrc ? ex_q.imm : fwd_rt;
  assign bus.exStoreData  = fwd_rt;
  assign bus.exAluControl = ex_q.alu_ctrl;
  assign bus.exShamt      = ex_q.shamt;
  assign bus.exWriteReg   = ex_q.write_reg;
  assign bus.exValid      = ex_q.valid;
  assign bus.exRegWrite   = ex_q.regwrite;
  assign bus.exMemRead    = ex_q.memread;
  assign bus.exMemWrite   = ex_q.memwrite;
  assign bus.exMemToReg   = ex_q.memtoreg;
  assign bus.exBranch     = ex_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, R-type capture, forwarding priority,
// load-use stall, flush, ALU control decode and asynchronous reset.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one active edge, then settle just past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 0;
    bus.idValid = 0; bus.idRegWrite = 0; bus.idMemRead = 0; bus.idMemWrite = 0;
    bus.idMemToReg = 0; bus.idBranch = 0; bus.idAluSrc = 0; bus.idRegDst = 0;
    bus.idAluOp = 2'b00; bus.idFunct = 6'h00; bus.idShamt = 5'd0;
    bus.idRs = 5'd0; bus.idRt = 5'd0; bus.idRd = 5'd0;
    bus.idReadData1 = 32'd0; bus.idReadData2 = 32'd0; bus.idImm = 32'd0;
    bus.memRegWrite = 0; bus.memWriteReg = 5'd0; bus.memAluResult = 32'd0;
    bus.wbRegWrite = 0; bus.wbWriteReg = 5'd0; bus.wbWriteData = 32'd0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clear_inputs();

    // reset state
    #2;
    check("rst_exValid",   {31'd0, bus.exValid},    32'd0);
    check("rst_exRegWrite",{31'd0, bus.exRegWrite}, 32'd0);
    check("rst_aluctrl",   {28'd0, bus.exAluControl}, 32'h0);
    check("rst_stall",     {31'd0, bus.stall},      32'd0);
    check("rst_aluin1",    bus.exAluIn1,            32'd0);
    #10 rst_n = 1'b1;

    // R-type sub $10 = $8 - $9
    bus.idValid = 1; bus.idRegWrite = 1; bus.idRegDst = 1;
    bus.idAluOp = 2'b10; bus.idFunct = 6'h22;
    bus.idRs = 5'd8; bus.idRt = 5'd9; bus.idRd = 5'd10;
    bus.idReadData1 = 32'd100; bus.idReadData2 = 32'd30;
    step();
    check("sub_aluctrl",  {28'd0, bus.exAluControl}, 32'b0110);
    check("sub_aluin1",   bus.exAluIn1,  32'd100);
    check("sub_aluin2",   bus.exAluIn2,  32'd30);
    check("sub_writereg", {27'd0, bus.exWriteReg}, 32'd10);
    check("sub_valid",    {31'd0, bus.exValid}, 32'd1);
    check("sub_regwrite", {31'd0, bus.exRegWrite}, 32'd1);

    // forwarding priority on rs=8
    bus.memRegWrite = 1; bus.memWriteReg = 5'd8; bus.memAluResult = 32'd7;
    bus.wbRegWrite  = 1; bus.wbWriteReg  = 5'd8; bus.wbWriteData  = 32'd9;
    #1;
    check("fwd_mem_over_wb", bus.exAluIn1, 32'd7);
    check("fwd_rt_untouched", bus.exAluIn2, 32'd30);
    bus.memRegWrite = 0;
    #1;
    check("fwd_wb_only", bus.exAluIn1, 32'd9);
    bus.wbWriteReg = 5'd9; bus.wbWriteData = 32'hABCD;
    #1;
    check("fwd_wb_rt_in2",   bus.exAluIn2,    32'hABCD);
    check("fwd_wb_rt_store", bus.exStoreData, 32'hABCD);
    check("fwd_wb_rs_miss",  bus.exAluIn1,    32'd100);

    // $0 never forwards; immediate operand; rt destination
    bus.memRegWrite = 0; bus.wbRegWrite = 0;
    bus.idRs = 5'd0; bus.idRt = 5'd3; bus.idRd = 5'd20; bus.idRegDst = 0;
    bus.idAluOp = 2'b00; bus.idAluSrc = 1; bus.idImm = 32'h1234;
    bus.idReadData1 = 32'h55; bus.idReadData2 = 32'h66;
    step();
    bus.memRegWrite = 1; bus.memWriteReg = 5'd0; bus.memAluResult = 32'hDEAD;
    bus.wbRegWrite  = 1; bus.wbWriteReg  = 5'd0; bus.wbWriteData  = 32'hBEEF;
    #1;
    check("zero_no_fwd",   bus.exAluIn1, 32'h55);
    check("imm_aluin2",    bus.exAluIn2, 32'h1234);
    check("imm_store",     bus.exStoreData, 32'h66);
    check("addi_aluctrl",  {28'd0, bus.exAluControl}, 32'b0010);
    check("rt_writereg",   {27'd0, bus.exWriteReg}, 32'd3);

    // load-use: lw $5 then add using $5
    clear_inputs();
    bus.idValid = 1; bus.idRegWrite = 1; bus.idMemRead = 1; bus.idMemToReg = 1;
    bus.idAluSrc = 1; bus.idAluOp = 2'b00; bus.idRs = 5'd1; bus.idRt = 5'd5;
    step();
    bus.idMemRead = 0; bus.idMemToReg = 0; bus.idAluSrc = 0; bus.idRegDst = 1;
    bus.idAluOp = 2'b10; bus.idFunct = 6'h20;
    bus.idRs = 5'd5; bus.idRt = 5'd2; bus.idRd = 5'd6;
    #1;
    check("lu_stall",      {31'd0, bus.stall}, 32'd1);
    check("lu_ex_memread", {31'd0, bus.exMemRead}, 32'd1);
    check("lu_ex_wreg",    {27'd0, bus.exWriteReg}, 32'd5);
    step();
    check("bubble_valid",    {31'd0, bus.exValid}, 32'd0);
    check("bubble_regwrite", {31'd0, bus.exRegWrite}, 32'd0);
    check("bubble_memread",  {31'd0, bus.exMemRead}, 32'd0);
    check("bubble_memtoreg", {31'd0, bus.exMemToReg}, 32'd0);
    check("stall_cleared",   {31'd0, bus.stall}, 32'd0);
    step();
    check("add_after_stall_valid", {31'd0, bus.exValid}, 32'd1);
    check("add_after_stall_ctrl",  {28'd0, bus.exAluControl}, 32'b0010);
    check("add_after_stall_wreg",  {27'd0, bus.exWriteReg}, 32'd6);

    // flush of a valid sw
    clear_inputs();
    bus.idValid = 1; bus.idMemWrite = 1; bus.idAluSrc = 1; bus.idBranch = 1;
    bus.idRs = 5'd4; bus.idRt = 5'd7; bus.flush = 1;
    step();
    check("flush_memwrite", {31'd0, bus.exMemWrite}, 32'd0);
    check("flush_valid",    {31'd0, bus.exValid}, 32'd0);
    check("flush_branch",   {31'd0, bus.exBranch}, 32'd0);
    bus.flush = 0;
    step();
    check("sw_memwrite", {31'd0, bus.exMemWrite}, 32'd1);

    // ALU control decode corners
    clear_inputs();
    bus.idValid = 1; bus.idRegWrite = 1; bus.idAluOp = 2'b10; bus.idFunct = 6'h3F;
    step();
    check("inv_funct_ctrl", {28'd0, bus.exAluControl}, 32'b1111);
    check("inv_funct_rw",   {31'd0, bus.exRegWrite}, 32'd1);
    bus.idFunct = 6'h2A; bus.idShamt = 5'd17;
    step();
    check("slt_ctrl", {28'd0, bus.exAluControl}, 32'b0111);
    check("shamt",    {27'd0, bus.exShamt}, 32'd17);
    bus.idFunct = 6'h02;
    step();
    check("srl_ctrl", {28'd0, bus.exAluControl}, 32'b1010);
    bus.idFunct = 6'h27;
    step();
    check("nor_ctrl", {28'd0, bus.exAluControl}, 32'b1100);
    bus.idAluOp = 2'b01;
    step();
    check("aluop01_ctrl", {28'd0, bus.exAluControl}, 32'b0110);
    bus.idAluOp = 2'b11;
    step();
    check("aluop11_ctrl", {28'd0, bus.exAluControl}, 32'b0001);

    // async reset mid-stream with a load-use pending
    clear_inputs();
    bus.idValid = 1; bus.idRegWrite = 1; bus.idMemRead = 1; bus.idAluOp = 2'b10;
    bus.idFunct = 6'h25; bus.idRt = 5'd12;
    step();
    bus.idMemRead = 0; bus.idRs = 5'd12;
    #1;
    check("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",    {31'd0, bus.exValid}, 32'd0);
    check("arst_regwrite", {31'd0, bus.exRegWrite}, 32'd0);
    check("arst_memread",  {31'd0, bus.exMemRead}, 32'd0);
    check("arst_aluctrl",  {28'd0, bus.exAluControl}, 32'h0);
    check("arst_stall",    {31'd0, bus.stall}, 32'd0);
    #3 rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // bound on total runtime
  initial begin
    #5000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that feeds the execute-stage ALU. Captures decoded operands and control from the decode stage each cycle, translates the ALU-op class plus funct into the ALU's 4-bit control code, resolves EX operand forwarding from the MEM and WB stages, and detects load-use hazards. It stalls decode and inserts a bubble when a hazard occurs, and it honours branch flushes.

## Interface
- No parameters. Data width is fixed at 32 bits and register index width at 5 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch-taken squash; the captured entry next cycle is a bubble
- idValid, idRegWrite, idMemRead, idMemWrite, idMemToReg, idBranch, idAluSrc, idRegDst  in  1 each  decode-stage control
- idAluOp  in  2  00 ADD, 01 SUB, 10 R-type (use funct), 11 OR
- idFunct  in  6  instruction funct field
- idShamt  in  5  shift amount
- idRs, idRt, idRd  in  5 each  register indices
- idReadData1, idReadData2, idImm  in  32 each  register-file reads; sign-extended immediate
- memRegWrite  in  1;  memWriteReg  in  5;  memAluResult  in  32  EX/MEM forwarding source
- wbRegWrite  in  1;  wbWriteReg  in  5;  wbWriteData  in  32  MEM/WB forwarding source
- stall  out  1  hold PC and IF/ID (combinational)
- exAluIn1, exAluIn2  out  32  forwarded ALU operands (combinational from registered state)
- exAluControl  out  4;  exShamt  out  5  ALU control code and shift amount
- exStoreData  out  32  forwarded rt value for stores
- exWriteReg  out  5  destination: rd if RegDst, else rt
- exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch  out  1  registered control

## Operation
- ALU control decode (from idAluOp and idFunct, registered):
  - 00 → 0010; 01 → 0110; 11 → 0001.
  - For 10, decode funct: 0x20/0x21 → 0010, 0x22/0x23 → 0110, 0x24 → 0000, 0x25 → 0001, 0x26 → 1011, 0x27 → 1100, 0x2A → 0111, 0x00 → 1001, 0x02 → 1010.
  - Any other funct → 1111 (ALU outputs 0). exRegWrite still follows the input.
- Forwarding, for each of rs and rt:
  - If memRegWrite, memWriteReg≠0 and memWriteReg==index → memAluResult.
  - Else if wbRegWrite, wbWriteReg≠0 and wbWriteReg==index → wbWriteData.
  - Else use the registered read data. MEM has priority over WB.
- Operand selection:
  - exAluIn1 = forwarded rs value.
  - exStoreData = forwarded rt value.
  - exAluIn2 = registered idImm if AluSrc, else the forwarded rt value.
- Load-use hazard: stall = exValid & exMemRead & exWriteReg≠0 & (exWriteReg==idRs | exWriteReg==idRt) & idValid.
- Capture rule at each clock edge:
  - flush → bubble.
  - Else stall → bubble.
  - Else capture the id* inputs.
- Bubble definition: exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg and exBranch are 0. Data fields are don't-care, but the RTL zeroes them.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - All registered fields 0, so every control output is 0.
  - exAluControl resets to 0000 (AND).
  - exAluIn1, exAluIn2 and exStoreData read 0 unless forwarding hits.
  - stall is 0.
- Latency: id* values presented before edge N appear on ex* after edge N (1 cycle).
- Forwarding and stall are purely combinational within the cycle. There is no added latency.
- A stall lasts exactly one cycle per load-use: the bubble clears exMemRead on the next edge.
- Flush and stall in the same cycle: a bubble is inserted. stall is still driven, and upstream handles the precedence.
- Reset asserted mid-instruction: the in-flight entry is discarded and no stall is asserted.

## Structure
- Shared package mips_pkg holds:
  - the ALU control codes (AND, OR, ADD, SUB, SLT, SLL, SRL, XOR, NOR, INVALID=1111)
  - the ALU-op class encodings
  - the funct constants
- Sub-module alu_ctrl_decode: combinational, idAluOp/idFunct → 4-bit code. It is reused by the single-cycle datapath.
- Forwarding muxes and hazard compare stay inline.

## Test plan
- R-type sub: idAluOp=10, funct=0x22, rs=$8=100, rt=$9=30, RegDst=1, rd=10. After 1 edge: exAluControl=0110, exAluIn1=100, exAluIn2=30, exWriteReg=10.
- Forward priority: exRs=8, with memWriteReg=8 (memAluResult=7) and wbWriteReg=8 (wbWriteData=9) both hitting → exAluIn1=7. Remove the MEM hit → 9. Repeat with index 0 → the registered value.
- Load-use: lw $5 in EX (exMemRead=1, exWriteReg=5), idRs=5 → stall=1. Next edge: exValid=0, all control 0. Following cycle: stall=0.
- Flush: flush=1 with a valid sw in ID → next cycle exMemWrite=0, exValid=0.
- Invalid funct 0x3F with aluOp=10 → exAluControl=1111. aluOp=11 → 0001.
- Async reset asserted between edges mid-stream → all ex control outputs 0 immediately, exAluControl=0000, stall=0.
